// File: rtl/dist_pkg.sv
// dist_pkg: shared constants and types for the distance smoothing filter.
//   DW            distance word width (matches the ranging core output)
//   MAX_DIST      largest legal distance code
//   WIN_LOG2_DFLT default log2 of the averaging window
//   SUM_W         running-sum width for the default window
//   state_t       filter FSM state {FILL, RUN}
package dist_pkg;

  localparam int              DW            = 19;
  localparam logic [DW-1:0]   MAX_DIST      = 19'd400000;
  localparam int              WIN_LOG2_DFLT = 2;
  localparam int              SUM_W         = DW + WIN_LOG2_DFLT;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dist_ring_buf.sv
// dist_ring_buf: 2^WIN_LOG2 x DW register ring holding the averaging window.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous flush of all entries
//   we        write enable
//   ptr       write pointer; also selects the entry about to be evicted
//   wdata     sample to store
//   evict     entry currently at ptr (oldest sample once the ring is full)
module dist_ring_buf #(
  parameter int DW       = dist_pkg::DW,
  parameter int WIN_LOG2 = dist_pkg::WIN_LOG2_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  logic [WIN_LOG2-1:0] ptr,
  input  logic [DW-1:0]       wdata,
  output logic [DW-1:0]       evict
);
  import dist_pkg::*;

  localparam int DEPTH = 1 << WIN_LOG2;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[ptr] <= wdata;
    end
  end

  // The write slot is the oldest entry, so it is read out before being overwritten.
  assign evict = mem[ptr];

endmodule

// File: rtl/dist_filter.sv
// dist_filter: range gate, optional outlier gate and power-of-two moving average
// on the ultrasonic distance word.
// Build option: define DIST_FILTER_OUTLIER_EN to build the outlier gate and its
// consecutive-reject counter; without it every in-range sample is accepted.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   din        raw distance code
//   din_vld    one-cycle pulse marking a new sample on din
//   clr        synchronous flush of the filter history (wins over din_vld)
//   data_out   filtered distance (floor of window mean), 0 while filling
//   dout_vld   one-cycle pulse on each data_out update once the window is full
//   flag_out   window full; data_out can be trusted
module dist_filter #(
  parameter int            DW       = dist_pkg::DW,
  parameter int            WIN_LOG2 = dist_pkg::WIN_LOG2_DFLT,
  parameter logic [DW-1:0] MAX_DIST = dist_pkg::MAX_DIST,
  parameter logic [DW-1:0] THRESH   = DW'(5000),
  parameter int            REJ_MAX  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic          clr,
  output logic [DW-1:0] data_out,
  output logic          dout_vld,
  output logic          flag_out
);
  import dist_pkg::*;

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int ACC_W = DW + WIN_LOG2;

  if (WIN_LOG2 < 1 || WIN_LOG2 > 4 || REJ_MAX < 2 || THRESH > MAX_DIST) begin : g_cfg_err
    $error("dist_filter: illegal parameter set");
  end

  function automatic logic [DW-1:0] avg_floor(input logic [ACC_W-1:0] s);
    return s[ACC_W-1:WIN_LOG2];
  endfunction

  function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic signed [DW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d[DW-1:0];
  endfunction

  state_t              state_p0, state_nxt;
  logic [ACC_W-1:0]    sum_p0, sum_nxt;
  logic [WIN_LOG2-1:0] wr_ptr_p0;
  logic [WIN_LOG2-1:0] fill_cnt_p0;
  logic                vld_p0;
  logic [DW-1:0]       evict;
  logic                in_range, accept, fill_done, upd;

  assign in_range  = (din != '0) && (din <= MAX_DIST);
  assign fill_done = (state_p0 == FILL) && (fill_cnt_p0 == WIN_LOG2'(DEPTH - 1));

`ifdef DIST_FILTER_OUTLIER_EN
  localparam int REJ_W = $clog2(REJ_MAX);

  logic [REJ_W-1:0] rej_cnt_p0, rej_cnt_nxt;
  logic             outlier, rej_last;

  // Only a full window gives a meaningful reference to compare against.
  assign outlier  = (state_p0 == RUN) && (abs_diff(din, data_out) > THRESH);
  assign rej_last = (rej_cnt_p0 == REJ_W'(REJ_MAX - 1));
  assign accept   = din_vld && in_range && !clr && (!outlier || rej_last);

  always_comb begin
    rej_cnt_nxt = rej_cnt_p0;
    if (clr)
      rej_cnt_nxt = '0;
    else if (din_vld && in_range)
      rej_cnt_nxt = (outlier && !rej_last) ? rej_cnt_p0 + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rej_cnt_p0 <= '0;
    else     rej_cnt_p0 <= rej_cnt_nxt;
  end
`else
  assign accept = din_vld && in_range && !clr;
`endif

  assign upd     = accept && ((state_p0 == RUN) || fill_done);
  assign sum_nxt = sum_p0 + ACC_W'(din) - ((state_p0 == RUN) ? ACC_W'(evict) : '0);

  always_comb begin
    state_nxt = state_p0;
    if (clr)                    state_nxt = FILL;
    else if (accept && fill_done) state_nxt = RUN;
  end

  dist_ring_buf #(
    .DW       (DW),
    .WIN_LOG2 (WIN_LOG2)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .we    (accept),
    .ptr   (wr_ptr_p0),
    .wdata (din),
    .evict (evict)
  );

  // Stage p0: accept decision, ring write, running sum, FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0    <= FILL;
      sum_p0      <= '0;
      wr_ptr_p0   <= '0;
      fill_cnt_p0 <= '0;
      vld_p0      <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      if (clr) begin
        sum_p0      <= '0;
        wr_ptr_p0   <= '0;
        fill_cnt_p0 <= '0;
        vld_p0      <= 1'b0;
      end else begin
        vld_p0 <= upd;
        if (accept) begin
          sum_p0    <= sum_nxt;
          wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
          if (state_p0 == FILL) fill_cnt_p0 <= fill_cnt_p0 + 1'b1;
        end
      end
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      dout_vld <= 1'b0;
      flag_out <= 1'b0;
    end else if (clr) begin
      data_out <= '0;
      dout_vld <= 1'b0;
      flag_out <= 1'b0;
    end else begin
      dout_vld <= vld_p0;
      flag_out <= (state_p0 == RUN);
      if (vld_p0) data_out <= avg_floor(sum_p0);
    end
  end

endmodule
